// File: rtl/maxplus_dot_serial_pkg.sv
// Shared types and helpers for the serial max-plus dot product.
package maxplus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // All-ones code of a w-bit element, used as epsilon (-inf).
    function automatic logic [31:0] eps(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/maxplus_dot_serial_term.sv
// One max-plus term: epsilon check, widened add and strict compare with the
// running maximum.
module maxplus_term
    import maxplus_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W:0]   acc,
    input  logic         acc_eps,
    output logic         take,
    output logic [W:0]   sum
);

    localparam logic [W-1:0] EPS = W'(eps(W));

    logic term_eps;

    always_comb begin
        term_eps = (a == EPS) || (b == EPS);
        sum      = {1'b0, a} + {1'b0, b};
        // Strict compare so a tie keeps the earlier (lower) index.
        take     = !term_eps && (acc_eps || (sum > acc));
    end

endmodule

// File: rtl/maxplus_dot_serial.sv
// Serial max-plus dot product r = max_k(a[k] + b[k]), one term per cycle,
// reporting the winning value, its index and an all-epsilon flag.
//
// state | meaning
// IDLE  | ready for a new operand pair
// ACC   | evaluating term k, updating the running maximum
// DONE  | result held until the consumer takes it
module maxplus_dot_serial
    import maxplus_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int W  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  vec_a,
    input  logic [N*W-1:0]  vec_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W:0]      result,
    output logic [CW-1:0]   result_idx,
    output logic            result_eps
);

    localparam logic [CW-1:0] K_LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  k_q, k_d;
    logic [N*W-1:0] a_q, a_d, b_q, b_d;
    logic [W:0]     acc_q, acc_d;
    logic           acc_eps_q, acc_eps_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W:0]     result_q, result_d;
    logic [CW-1:0]  result_idx_q, result_idx_d;
    logic           result_eps_q, result_eps_d;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];
    logic           take;
    logic [W:0]     sum;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign a_arr[g] = a_q[g*W +: W];
        assign b_arr[g] = b_q[g*W +: W];
    end

    maxplus_term #(.W(W)) u_term (
        .a       (a_arr[k_q]),
        .b       (b_arr[k_q]),
        .acc     (acc_q),
        .acc_eps (acc_eps_q),
        .take    (take),
        .sum     (sum)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        acc_eps_d    = acc_eps_q;
        idx_d        = idx_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        result_idx_d = result_idx_q;
        result_eps_d = result_eps_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_d        = vec_a;
                    b_d        = vec_b;
                    k_d        = '0;
                    acc_d      = '0;
                    acc_eps_d  = 1'b1;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ACC;
                end
            end
            ACC: begin
                if (take) begin
                    acc_d     = sum;
                    acc_eps_d = 1'b0;
                    idx_d     = k_q;
                end
                // acc/idx stay zero while every term so far was epsilon.
                if (k_q == K_LAST) begin
                    result_d     = acc_d;
                    result_idx_d = idx_d;
                    result_eps_d = acc_eps_d;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            acc_eps_q    <= 1'b1;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            result_idx_q <= '0;
            result_eps_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            acc_eps_q    <= acc_eps_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            result_idx_q <= result_idx_d;
            result_eps_q <= result_eps_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_idx = result_idx_q;
    assign result_eps = result_eps_q;

endmodule

// File: tb/tb_maxplus_dot_serial.sv
// Bench for maxplus_dot_serial: directed corner cases plus random vectors
// against a max-then-first-index reference model.
module tb_maxplus_dot_serial;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int CW = 2;
    localparam int EPS_V = 255;

    typedef int vec_t [N];

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] vec_a = '0;
    logic [N*W-1:0] vec_b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W:0]     result;
    logic [CW-1:0]  result_idx;
    logic           result_eps;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    maxplus_dot_serial #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vec_a      (vec_a),
        .vec_b      (vec_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_idx (result_idx),
        .result_eps (result_eps)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input vec_t v);
        logic [N*W-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[k*W +: W] = v[k][W-1:0];
        return p;
    endfunction

    // Reference: maximum over non-epsilon sums, then the first index holding it.
    function automatic void model(input vec_t a, input vec_t b,
                                  output int r, output int idx, output int e);
        int sums [N];
        int best;
        best = -1;
        for (int k = 0; k < N; k++) begin
            sums[k] = (a[k] == EPS_V || b[k] == EPS_V) ? -1 : a[k] + b[k];
            if (sums[k] > best) best = sums[k];
        end
        e = (best < 0) ? 1 : 0;
        r = (best < 0) ? 0 : best;
        idx = 0;
        if (best >= 0) begin
            for (int k = N - 1; k >= 0; k--) if (sums[k] == best) idx = k;
        end
    endfunction

    task automatic accept(input vec_t a, input vec_t b, input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk({tag, ".ready_timeout"}, int'(in_ready), 1);
        vec_a    = pack(a);
        vec_b    = pack(b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic await_result(input vec_t a, input vec_t b, input string tag);
        int r, idx, e, cnt;
        model(a, b, r, idx, e);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, ".latency"}, cnt, N);
        chk({tag, ".result"}, int'(result), r);
        chk({tag, ".idx"}, int'(result_idx), idx);
        chk({tag, ".eps"}, int'(result_eps), e);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drain_valid"}, int'(out_valid), 0);
        chk({tag, ".drain_ready"}, int'(in_ready), 1);
    endtask

    task automatic run_vec(input vec_t a, input vec_t b, input string tag);
        accept(a, b, tag);
        await_result(a, b, tag);
        drain(tag);
    endtask

    function automatic int rand_elem();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return EPS_V;
        if (r < 5) return int'($urandom_range(0, 7));
        if (r == 5) return 254;
        return int'($urandom_range(0, 254));
    endfunction

    initial begin
        vec_t a1 = '{1, 2, 3};
        vec_t b1 = '{10, 5, 20};
        vec_t a2 = '{255, 4, 4};
        vec_t b2 = '{0, 6, 6};
        vec_t a3 = '{255, 255, 255};
        vec_t b3 = '{7, 0, 254};
        vec_t a4 = '{254, 0, 0};
        vec_t b4 = '{254, 1, 1};
        vec_t ar, br;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset.in_ready", int'(in_ready), 1);
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.result", int'(result), 0);
        chk("reset.idx", int'(result_idx), 0);
        chk("reset.eps", int'(result_eps), 1);

        run_vec(a1, b1, "case1");
        run_vec(a2, b2, "case2_tie");
        run_vec(a3, b3, "case3_alleps");
        run_vec(a4, b4, "case4_wide");

        // Back-pressure in DONE while a new vector is offered.
        accept(a1, b1, "case5a");
        await_result(a1, b1, "case5a");
        vec_a     = pack(a4);
        vec_b     = pack(b4);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("case5.hold_valid", int'(out_valid), 1);
            chk("case5.hold_ready", int'(in_ready), 0);
            chk("case5.hold_result", int'(result), 23);
            chk("case5.hold_idx", int'(result_idx), 2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("case5.idle_valid", int'(out_valid), 0);
        chk("case5.idle_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("case5.taken_ready", int'(in_ready), 0);
        await_result(a4, b4, "case5b");
        drain("case5b");

        // Reset in the middle of accumulation (k=1).
        accept(a1, b1, "case6a");
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("case6.in_ready", int'(in_ready), 1);
        chk("case6.out_valid", int'(out_valid), 0);
        chk("case6.eps", int'(result_eps), 1);
        chk("case6.result", int'(result), 0);
        run_vec(a1, b1, "case6b");

        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < N; k++) begin
                ar[k] = rand_elem();
                br[k] = rand_elem();
            end
            run_vec(ar, br, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
